// File: rtl/fnd_scan_display_pkg.sv
// Shared constants for the FND scan display: active-low segment patterns
// ({dp,g,f,e,d,c,b,a}) and the bit layout of the packed 24-bit time word.
package fnd_scan_display_pkg;

    // Active-low seven-segment patterns, dp off (bit 7 high).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int unsigned DP_BIT   = 7;

    // Packed time word field layout.
    localparam int unsigned MSEC_LSB = 0;
    localparam int unsigned MSEC_W   = 7;
    localparam int unsigned SEC_LSB  = 7;
    localparam int unsigned SEC_W    = 6;
    localparam int unsigned MIN_LSB  = 13;
    localparam int unsigned MIN_W    = 6;
    localparam int unsigned HOUR_LSB = 19;
    localparam int unsigned HOUR_W   = 5;

endpackage

// File: rtl/fnd_bcd_decoder.sv
// Combinational digit-to-segment decoder.
// Ports:
//   value  - 4-bit digit value; anything above 9 shows blank
//   dp_on  - 1 lights the decimal point
//   seg_c  - active-low segments {dp,g,f,e,d,c,b,a}
module fnd_bcd_decoder
    import fnd_scan_display_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp_on,
    output logic [7:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (value)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
        if (dp_on) begin
            seg_c[DP_BIT] = 1'b0;
        end
    end

endmodule

// File: rtl/fnd_scan_display.sv
// Four-digit common-anode 7-segment scan driver for the packed time word.
// Shows sec:msec (sel_display=0) or hour:min (sel_display=1), one digit per
// scan slot, with a centre decimal point blinking from the msec field.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   sel_display   - 0 = sec:msec, 1 = hour:min
//   fnd_in_data   - {hour[4:0], min[5:0], sec[5:0], msec[6:0]}
//   fnd_digit     - active-low digit enables, bit 0 = rightmost (registered)
//   fnd_data      - active-low segments {dp,g,f,e,d,c,b,a} (registered)
module fnd_scan_display
    import fnd_scan_display_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_display,
    input  logic [23:0] fnd_in_data,
    output logic [3:0]  fnd_digit,
    output logic [7:0]  fnd_data
);

    localparam int unsigned SCAN_DIV = CLK_FREQ / SCAN_HZ;
    localparam int unsigned DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]  scan_div;
    logic              scan_tick_c;
    logic [1:0]        digit_idx;
    logic [MSEC_W-1:0] msec_c;
    logic [SEC_W-1:0]  sec_c;
    logic [MIN_W-1:0]  min_c;
    logic [HOUR_W-1:0] hour_c;
    logic [6:0]        lower_c;
    logic [5:0]        upper_c;
    logic [3:0]        digit_val_c;
    logic              dp_on_c;
    logic [7:0]        seg_c;

    assign scan_tick_c = (scan_div == DIV_MAX);

    // Scan divider and digit index; the index steps once per slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_div  <= '0;
            digit_idx <= '0;
        end else begin
            if (scan_tick_c) begin
                scan_div  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                scan_div  <= scan_div + DIV_W'(1);
            end
        end
    end

    assign msec_c = fnd_in_data[MSEC_LSB +: MSEC_W];
    assign sec_c  = fnd_in_data[SEC_LSB  +: SEC_W];
    assign min_c  = fnd_in_data[MIN_LSB  +: MIN_W];
    assign hour_c = fnd_in_data[HOUR_LSB +: HOUR_W];

    // Field pair selection; both pairs zero-extended to a common width.
    assign lower_c = sel_display ? 7'(min_c)  : msec_c;
    assign upper_c = sel_display ? 6'(hour_c) : sec_c;

    // Digit value on full field width: an out-of-range tens digit (e.g.
    // msec=127 -> 12) is passed through and decodes to blank.
    always_comb begin
        digit_val_c = 4'd0;
        case (digit_idx)
            2'd0: digit_val_c = 4'(lower_c % 7'd10);
            2'd1: digit_val_c = 4'(lower_c / 7'd10);
            2'd2: digit_val_c = 4'(upper_c % 6'd10);
            2'd3: digit_val_c = 4'(upper_c / 6'd10);
            default: digit_val_c = 4'd0;
        endcase
    end

    // Centre dp follows msec regardless of mode: lit for the first half second.
    assign dp_on_c = (digit_idx == 2'd2) && (msec_c < 7'd50);

    fnd_bcd_decoder u_decoder (
        .value (digit_val_c),
        .dp_on (dp_on_c),
        .seg_c (seg_c)
    );

    // Registered pins, one clk behind the index and input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fnd_digit <= 4'b1111;
            fnd_data  <= SEG_BLANK;
        end else begin
            fnd_digit <= ~(4'b0001 << digit_idx);
            fnd_data  <= seg_c;
        end
    end

endmodule

// File: tb/tb_fnd_scan_display.sv
module tb_fnd_scan_display;

    logic        clk;
    logic        reset;
    logic        sel_display;
    logic [23:0] fnd_in_data;
    logic [3:0]  fnd_digit;
    logic [7:0]  fnd_data;

    int checks;
    int failures;
    int n;

    fnd_scan_display #(
        .CLK_FREQ (1000),
        .SCAN_HZ  (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sel_display (sel_display),
        .fnd_in_data (fnd_in_data),
        .fnd_digit   (fnd_digit),
        .fnd_data    (fnd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pack(input int hour, input int min,
                                         input int sec, input int msec);
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [6:0] ms;
        h  = 5'(hour);
        m  = 6'(min);
        s  = 6'(sec);
        ms = 7'(msec);
        return {h, m, s, ms};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic go_to(input int target);
        while (n < target) step();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        n           = 0;
        reset       = 1'b1;
        sel_display = 1'b0;
        fnd_in_data = pack(0, 0, 42, 37);

        repeat (3) begin @(posedge clk); #1; end
        chk("reset_digit", {4'h0, fnd_digit}, 8'h0F);
        chk("reset_data", fnd_data, 8'hFF);

        // Release; n counts rising edges since release.
        reset = 1'b0;
        n = 0;
        go_to(1);
        chk("s0_idx0_digit", {4'h0, fnd_digit}, 8'h0E);
        chk("s0_idx0_data", fnd_data, 8'hF8);
        go_to(10);
        chk("s0_idx0_slot_end", {4'h0, fnd_digit}, 8'h0E);
        go_to(11);
        chk("s0_idx1_digit", {4'h0, fnd_digit}, 8'h0D);
        chk("s0_idx1_data", fnd_data, 8'hB0);
        go_to(21);
        chk("s0_idx2_digit", {4'h0, fnd_digit}, 8'h0B);
        chk("s0_idx2_data_dp", fnd_data, 8'h24);
        go_to(31);
        chk("s0_idx3_digit", {4'h0, fnd_digit}, 8'h07);
        chk("s0_idx3_data", fnd_data, 8'h99);
        go_to(41);
        chk("wrap_idx0_digit", {4'h0, fnd_digit}, 8'h0E);
        chk("wrap_idx0_data", fnd_data, 8'hF8);

        // hour:min mode, msec past half second.
        sel_display = 1'b1;
        fnd_in_data = pack(23, 5, 0, 80);
        go_to(42);
        chk("s1_idx0_data", fnd_data, 8'h92);
        chk("s1_idx0_digit", {4'h0, fnd_digit}, 8'h0E);
        go_to(51);
        chk("s1_idx1_data", fnd_data, 8'hC0);
        go_to(61);
        chk("s1_idx2_data_nodp", fnd_data, 8'hB0);
        go_to(71);
        chk("s1_idx3_data", fnd_data, 8'hA4);

        // msec=127: tens digit 12 blanks.
        go_to(81);
        sel_display = 1'b0;
        fnd_in_data = pack(23, 5, 59, 127);
        go_to(82);
        chk("m127_idx0_data", fnd_data, 8'hF8);
        go_to(91);
        chk("m127_idx1_blank", fnd_data, 8'hFF);
        go_to(101);
        chk("m127_idx2_nodp", fnd_data, 8'h90);

        // Toggle mode mid-slot at idx2.
        go_to(103);
        sel_display = 1'b1;
        #1;
        chk("toggle_no_early", fnd_data, 8'h90);
        go_to(104);
        chk("toggle_data", fnd_data, 8'hB0);
        chk("toggle_digit", {4'h0, fnd_digit}, 8'h0B);
        go_to(110);
        chk("toggle_slot_end", {4'h0, fnd_digit}, 8'h0B);
        go_to(111);
        chk("toggle_next_digit", {4'h0, fnd_digit}, 8'h07);
        chk("toggle_next_data", fnd_data, 8'hA4);

        // Reset mid-slot at idx3: immediate blank.
        go_to(115);
        reset = 1'b1;
        #1;
        chk("midrst_digit", {4'h0, fnd_digit}, 8'h0F);
        chk("midrst_data", fnd_data, 8'hFF);
        repeat (3) begin @(posedge clk); #1; end
        chk("midrst_hold_digit", {4'h0, fnd_digit}, 8'h0F);
        chk("midrst_hold_data", fnd_data, 8'hFF);
        reset = 1'b0;
        n = 0;
        go_to(1);
        chk("rel_idx0_digit", {4'h0, fnd_digit}, 8'h0E);
        chk("rel_idx0_data", fnd_data, 8'h92);
        go_to(10);
        chk("rel_idx0_full_slot", {4'h0, fnd_digit}, 8'h0E);
        go_to(11);
        chk("rel_idx1_digit", {4'h0, fnd_digit}, 8'h0D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
